// File: rtl/ram_burst_ctrl_if.sv
// Request/response bundle for ram_burst_ctrl: write and burst-read requests
// in, one read word per cycle out.
interface ram_burst_ctrl_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [WIDTH-1:0]  req_wdata;
    logic              wr_par_flip;
    logic              abort;
    logic              rd_valid;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_last;
    logic              rd_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_len, req_wdata, wr_par_flip, abort,
        input  req_ready, rd_valid, rd_data, rd_last, rd_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, req_wdata, wr_par_flip, abort,
        output req_ready, rd_valid, rd_data, rd_last, rd_err, busy
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Single-port RAM controller: 1-cycle writes, burst reads streamed one word per
// cycle with wrap-around and abort. Define PARITY_EN for a stored parity bit.
module ram_burst_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_burst_ctrl_if.slave      bus
);
`ifdef PARITY_EN
    localparam int unsigned MEM_W = WIDTH + 1;
`else
    localparam int unsigned MEM_W = WIDTH;
`endif

    typedef enum logic {IDLE, READ} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W-1:0]  rem;
    logic              wr_en, rd_start, rd_issue;

    logic [MEM_W-1:0]  mem [2**ADDR_W];
    logic [MEM_W-1:0]  wr_word, rd_word;
    logic              rd_err_nxt;

    logic              rd_valid_q, rd_last_q, rd_err_q;
    logic [WIDTH-1:0]  rd_data_q;

    assign rd_word = mem[addr_cnt];

`ifdef PARITY_EN
    assign wr_word    = {(^bus.req_wdata) ^ bus.wr_par_flip, bus.req_wdata};
    assign rd_err_nxt = (^rd_word[WIDTH-1:0]) != rd_word[WIDTH];
`else
    logic unused_par_flip;
    assign unused_par_flip = bus.wr_par_flip;
    assign wr_word         = bus.req_wdata;
    assign rd_err_nxt      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Abort takes priority over the final read, so an aborted burst never ends with rd_last.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_start  = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_we) begin
                        wr_en = 1'b1;
                    end else begin
                        rd_start  = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    rd_issue = 1'b1;
                    if (rem == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[bus.req_addr] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_cnt   <= '0;
            rem        <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            if (rd_start) begin
                addr_cnt <= bus.req_addr;
                rem      <= bus.req_len;
            end else if (rd_issue) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
                rem      <= rem - LEN_W'(1);
            end
            rd_valid_q <= rd_issue;
            rd_data_q  <= rd_issue ? rd_word[WIDTH-1:0] : '0;
            rd_last_q  <= rd_issue && (rem == '0);
            rd_err_q   <= rd_issue && rd_err_nxt;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state == READ);
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.rd_err    = rd_err_q;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl: stimulus pushes expected read words,
// a negedge monitor pops and compares them; timing is checked directly.
module tb_ram_burst_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    ram_burst_ctrl_if #(.WIDTH(16), .ADDR_W(10), .LEN_W(4)) bus ();
    ram_burst_ctrl #(.WIDTH(16), .ADDR_W(10), .LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [15:0] smem [0:1023];
    logic        sflip [0:1023];
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.rd_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_word", 32'(bus.rd_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rd_data", 32'(bus.rd_data), 32'(e.data));
                    check("rd_last", 32'(bus.rd_last), 32'(e.last));
                    check("rd_err",  32'(bus.rd_err),  32'(e.err));
                end
            end else begin
                check("idle_zero", {14'd0, bus.rd_data, bus.rd_last, bus.rd_err}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [15:0] d, input logic f);
        bus.req_valid   = 1'b1;
        bus.req_we      = 1'b1;
        bus.req_addr    = a[9:0];
        bus.req_wdata   = d;
        bus.wr_par_flip = f;
        smem[a]  = d;
        sflip[a] = f;
        tick();
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.wr_par_flip = 1'b0;
    endtask

    task automatic push_burst(input int a, input int len, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            int   ad;
            ad     = (a + i) % 1024;
            e.data = smem[ad];
            e.last = (i == len);
`ifdef PARITY_EN
            e.err  = sflip[ad];
`else
            e.err  = 1'b0;
`endif
            q.push_back(e);
        end
    endtask

    // Returns one cycle after the accepting edge (C1 + 1).
    task automatic do_read(input int a, input int len, input int n_deliver);
        int w;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a[9:0];
        bus.req_len   = len[3:0];
        w = 0;
        while (!bus.req_ready && w < 100) begin
            w++;
            tick();
        end
        if (w >= 100) check("ready_timeout", 32'(w), 32'd0);
        push_burst(a, len, n_deliver);
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int n_low, n_val, n_busy;
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.req_wdata   = '0;
        bus.wr_par_flip = 1'b0;
        bus.abort       = 1'b0;

        #12;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_valid", 32'(bus.rd_valid),  32'd0);
        check("rst_data",  32'(bus.rd_data),   32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_last_err", {30'd0, bus.rd_last, bus.rd_err}, 32'd0);
        rst = 1'b1;
        tick();

        // write then read, latency and rd_last placement
        do_write(5, 16'h1234, 1'b0);
        do_write(6, 16'hBEEF, 1'b0);
        do_read(5, 1, 2);
        check("c1_valid", 32'(bus.rd_valid),  32'd0);
        check("c1_busy",  32'(bus.busy),      32'd1);
        check("c1_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("c2_valid", 32'(bus.rd_valid),  32'd1);
        check("c2_last",  32'(bus.rd_last),   32'd0);
        tick();
        check("c3_valid", 32'(bus.rd_valid),  32'd1);
        check("c3_last",  32'(bus.rd_last),   32'd1);
        check("c3_ready", 32'(bus.req_ready), 32'd1);
        tick();
        check("c4_valid", 32'(bus.rd_valid),  32'd0);

        // wrap-around across the top of memory
        do_write(1023, 16'hAAAA, 1'b0);
        do_write(0,    16'h5555, 1'b0);
        do_write(1,    16'h0F0F, 1'b0);
        do_read(1023, 2, 3);
        n_busy = 0;
        while (bus.busy && n_busy < 50) begin
            n_busy++;
            tick();
        end
        check("wrap_busy_cycles", 32'(n_busy), 32'd3);
        repeat (3) tick();

        // back-to-back bursts with req_valid held
        for (int i = 0; i < 16; i++) do_write(i, 16'hC000 + 16'(i * 17), 1'b0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'd0;
        bus.req_len   = 4'd15;
        push_burst(0, 15, 16);
        tick();
        bus.req_addr  = 10'd5;
        bus.req_len   = 4'd1;
        push_burst(5, 1, 2);
        n_low = 0;
        n_val = 0;
        while (!bus.req_ready && n_low < 40) begin
            n_low++;
            if (bus.rd_valid) n_val++;
            tick();
        end
        check("b2b_ready_low", 32'(n_low), 32'd16);
        check("b2b_valid_run", 32'(n_val), 32'd15);
        check("b2b_last_with_ready", {30'd0, bus.rd_valid, bus.rd_last}, 32'd3);
        tick();
        bus.req_valid = 1'b0;
        check("b2b_gap", 32'(bus.rd_valid), 32'd0);
        tick();
        check("b2b_second_first", 32'(bus.rd_valid), 32'd1);
        repeat (3) tick();

        // abort in the third READ cycle
        for (int i = 100; i < 108; i++) do_write(i, 16'h7700 + 16'(i), 1'b0);
        do_read(100, 7, 2);
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        check("abort_valid", 32'(bus.rd_valid),  32'd0);
        repeat (4) tick();
        check("abort_drained", 32'(q.size()), 32'd0);

        // reset mid-burst, memory retained
        do_read(100, 7, 2);
        tick();
        tick();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.rd_valid),  32'd0);
        check("mid_rst_data",  32'(bus.rd_data),   32'd0);
        check("mid_rst_busy",  32'(bus.busy),      32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        do_read(100, 1, 2);
        repeat (4) tick();

        // parity error injection
        do_write(9,  16'h0001, 1'b1);
        do_write(10, 16'h0003, 1'b0);
        do_read(9, 1, 2);
        repeat (4) tick();

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Parametrised single-port RAM controller with an internal synchronous memory. It accepts single-word writes and burst reads through a valid/ready request port and streams read data at one word per cycle. Read data is zero-gated when not valid. Bursts can be aborted, and the address wraps at the top of memory. It sits between a lab-level control FSM and local storage, replacing fixed-width single-word read blocks.

Parameters:
WIDTH, 16, data word width in bits
ADDR_W, 10, address width; memory depth is 2**ADDR_W words
LEN_W, 4, burst length field width; a burst is 1..2**LEN_W words

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request; high only in IDLE
req_we  input  1  1 = write request, 0 = burst read request
req_addr  input  ADDR_W  write address or burst start address
req_len  input  LEN_W  burst length minus 1; ignored for writes
req_wdata  input  WIDTH  write data
wr_par_flip  input  1  invert the stored parity bit on this write; used only with PARITY_EN
abort  input  1  terminate the current burst
rd_valid  output  1  rd_data holds a valid word this cycle
rd_data  output  WIDTH  read word; 0 whenever rd_valid=0
rd_last  output  1  final word of a burst that was not aborted
rd_err  output  1  parity mismatch on the current word (only with PARITY_EN)
busy  output  1  high when state is READ

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_ready=1, rd_valid=0, rd_data=0, rd_last=0, rd_err=0, busy=0. Memory contents are not cleared.
- Accept: a request is accepted when req_valid=1 and req_ready=1 at a rising edge.
- Write accept: the memory at req_addr is loaded with req_wdata on that edge. State stays IDLE, so back-to-back writes run at 1 per cycle. No response is generated.
- Read accept: addr_cnt is loaded with req_addr, rem is loaded with req_len, and state goes to READ.
- Each cycle in READ (abort=0):
  - mem[addr_cnt] is read on the edge.
  - addr_cnt increments, wrapping from 2**ADDR_W-1 to 0.
  - rem decrements.
  - When rem=0, state returns to IDLE on that edge.
- Read latency and output timing:
  - With C0 as the accept cycle, the first word appears with rd_valid=1 in C2.
  - Subsequent words follow on consecutive cycles with no gaps.
  - rd_valid, rd_data and rd_last are registered outputs.
  - rd_last=1 in the same cycle as the last word.
- Turnaround: req_ready rises in the same cycle the last word is presented. A new request may be accepted in that cycle. There is one non-accepting cycle per burst beyond its length.
- Abort: abort=1 sampled in READ means no read is issued on that edge. State goes to IDLE and rd_valid=0 from the next cycle. Words already registered have been delivered. rd_last is never asserted for an aborted burst. abort is ignored in IDLE.
- Simultaneous events: abort on the final READ cycle wins, so no last word and no rd_last are produced.
- Reset mid-burst: outputs go to reset values immediately and the burst is dropped.
- Memory: a write to an address being read is impossible, because req_ready=0 in READ.
- FSM: two states, IDLE and READ. Encoding is free.

Optional Feature:
PARITY_EN
- Defined:
  - Memory is WIDTH+1 bits wide.
  - On write, the stored parity bit is the XOR reduction of req_wdata, XORed with wr_par_flip.
  - On read, rd_err=1 when the XOR reduction of the stored data differs from the stored parity bit.
  - rd_err is registered and aligned with rd_valid, and is 0 when rd_valid=0.
- Undefined: memory is WIDTH bits wide, rd_err is tied to 0, and wr_par_flip is ignored.

Test Plan:
- Write then read: write 0x1234 to 5 and 0xBEEF to 6, then read with addr=5, len=1 -> rd_valid in C2 and C3 with rd_data 0x1234 then 0xBEEF, and rd_last=1 only in C3.
- Wrap-around: write 0xAAAA to 1023, 0x5555 to 0 and 0x0F0F to 1, then read addr=1023, len=2 -> data AAAA, 5555, 0F0F on consecutive cycles; rd_last on 0F0F; busy high for 3 cycles.
- Back-to-back and ready timing: read len=15 from 0, with req_valid held for a second read -> 16 consecutive valid words. req_ready=0 during READ and rises together with rd_last; the second burst's first word arrives 2 cycles after that.
- Abort: read len=7 from 100 and assert abort in the 3rd READ cycle -> exactly 2 words (mem[100], mem[101]) are delivered, no rd_last, and req_ready=1 the next cycle.
- Reset mid-burst: drop rst during a len=7 burst -> rd_valid and rd_data are 0 immediately. After release, a re-read returns the previously written data unchanged.
- PARITY_EN: write 0x0001 with wr_par_flip=1 to 9 and 0x0003 with wr_par_flip=0 to 10, then read addr=9, len=1 -> rd_err=1 on the first word and 0 on the second. Without the macro, rd_err=0 throughout.
